dma_copy: RTL and testbench
===========================

DMA_COPY -- requirements
Module: dma_copy

Interface
REQ-001 Parameter LEN_W, default 7, SHALL set the word-count width (max transfer 2^LEN_W-1 words).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request a transfer; sampled only in IDLE.
REQ-005 src_addr  input  32  SHALL give the byte address of the first source word.
REQ-006 dst_addr  input  32  SHALL give the byte address of the first destination word.
REQ-007 len  input  LEN_W  SHALL give the number of 32-bit words to copy.
REQ-008 src_inc, dst_inc  input  1 each  SHALL select post-increment by 4 (1) or fixed address (0), for peripheral registers such as 0xC000_000C ADC or 0xC000_0010 display0.
REQ-009 bus_req  output  1  SHALL request ownership of the data-memory port.
REQ-010 bus_gnt  input  1  SHALL indicate the port is granted this cycle.
REQ-011 mem_we  output  1, mem_a  output  32, mem_wd  output  32  SHALL drive the data-memory port (synchronous write on clk).
REQ-012 mem_rd  input  32  SHALL be combinational read data for mem_a, valid in the same cycle.
REQ-013 busy  output  1, done  output  1, error  output  1  SHALL report status.

Function
REQ-014 FSM states SHALL be IDLE, REQ, READ, WRITE, DONE.
REQ-015 IDLE: start=1 with src_addr[1:0]=0, dst_addr[1:0]=0, len!=0 SHALL latch addresses, len, inc flags and go to REQ.
REQ-016 IDLE: start=1 with a misaligned address or len=0 SHALL pulse error for exactly one cycle, stay IDLE, issue no access.
REQ-017 REQ: bus_req=1; bus_gnt=1 SHALL advance to READ, else stay.
REQ-018 READ with bus_gnt=1: mem_a=current src, mem_we=0; mem_rd SHALL be captured into the data register at the edge; go to WRITE.
REQ-019 WRITE with bus_gnt=1: mem_a=current dst, mem_wd=data register, mem_we=1; at the edge src/dst SHALL add 4 if their inc flag is set, count SHALL decrement; count reaching 0 goes to DONE, else READ.
REQ-020 READ/WRITE with bus_gnt=0 SHALL stall in place with mem_we=0 and no register change.
REQ-021 bus_req SHALL be 1 in REQ, READ, WRITE and 0 otherwise; busy identical.
REQ-022 DONE SHALL pulse done for one cycle, then return to IDLE.
REQ-023 With bus_gnt held 1, a start edge at cycle 0 SHALL yield done at cycle 2N+2 (2 cycles per word).
REQ-024 mem_we, mem_a, mem_wd SHALL be 0 in IDLE, REQ, DONE.
REQ-025 Address increment SHALL wrap modulo 2^32 (0xFFFF_FFFC + 4 = 0).
REQ-026 start while not IDLE SHALL be ignored.

Reset
REQ-027 reset=0 SHALL asynchronously force IDLE and zero all outputs and internal registers, including mid-transfer; writes already completed are not undone.

Structure
REQ-028 Package dma_pkg SHALL hold the state enum, WORD_BYTES=4 and LEN_W default.
REQ-029 No sub-module; single flat module.

Verification
REQ-030 RAM[0..3]=11,22,33,44; start src=0x0, dst=0x40, len=4, inc=1/1, gnt=1 -> RAM[16..19]=11,22,33,44, done at cycle 10.
REQ-031 src=0xC000_000C, src_inc=0, dst=0x80, len=3, adc_value=0x5A5 -> RAM[32..34]=0x5A5, mem_a on reads constant.
REQ-032 src=0x2, len=1 -> error pulse 1 cycle, no mem_we, busy stays 0.
REQ-033 len=4 transfer, bus_gnt dropped 3 cycles during WRITE of word 2 -> mem_we=0 while dropped, data correct, done delayed by 3 cycles.
REQ-034 reset asserted after first WRITE of len=4 -> all outputs 0 immediately, only first destination word written.

Source files
------------

// File: rtl/dma_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// dma_pkg - shared state encoding and constants for the dma_copy engine.
// Revision 1.0
// ============================================================================
package dma_pkg;

    localparam int WORD_BYTES    = 4;
    localparam int DEFAULT_LEN_W = 7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dma_copy.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// dma_copy - word-by-word memory copy engine sharing one data-memory port.
// Revision 1.0
// ============================================================================
module dma_copy
    import dma_pkg::*;
#(
    parameter int LEN_W = DEFAULT_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             src_inc,
    input  logic             dst_inc,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic             mem_we,
    output logic [31:0]      mem_a,
    output logic [31:0]      mem_wd,
    input  logic [31:0]      mem_rd,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam logic [31:0]      ADDR_STEP = 32'(WORD_BYTES);
    localparam logic [LEN_W-1:0] ONE_WORD  = LEN_W'(1);

    state_t           state;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [31:0]      data_reg;
    logic [LEN_W-1:0] count;
    logic             src_inc_q;
    logic             dst_inc_q;
    logic             req_ok;

    assign req_ok = (src_addr[1:0] == 2'b00) && (dst_addr[1:0] == 2'b00) && (len != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            data_reg  <= '0;
            count     <= '0;
            src_inc_q <= 1'b0;
            dst_inc_q <= 1'b0;
            bus_req   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (req_ok) begin
                            src_ptr   <= src_addr;
                            dst_ptr   <= dst_addr;
                            count     <= len;
                            src_inc_q <= src_inc;
                            dst_inc_q <= dst_inc;
                            bus_req   <= 1'b1;
                            busy      <= 1'b1;
                            state     <= REQ;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus_gnt) state <= READ;
                end
                READ: begin
                    if (bus_gnt) begin
                        data_reg <= mem_rd;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (bus_gnt) begin
                        // Fixed-address mode keeps peripheral registers targeted every word.
                        if (src_inc_q) src_ptr <= src_ptr + ADDR_STEP;
                        if (dst_inc_q) dst_ptr <= dst_ptr + ADDR_STEP;
                        count <= count - ONE_WORD;
                        if (count == ONE_WORD) begin
                            bus_req <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    bus_req <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // The port follows the grant combinationally so a withdrawn grant never writes.
    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        case (state)
            READ: begin
                mem_a = src_ptr;
            end
            WRITE: begin
                mem_a  = dst_ptr;
                mem_wd = data_reg;
                mem_we = bus_gnt;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_copy.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_dma_copy - randomized scoreboard bench for dma_copy with a word-level model.
// Revision 1.0
// ============================================================================
module tb_dma_copy;

    localparam int          LW       = 7;
    localparam logic [31:0] ADC_ADDR = 32'hC000_000C;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          start    = 1'b0;
    logic [31:0]   src_addr = '0;
    logic [31:0]   dst_addr = '0;
    logic [LW-1:0] len      = '0;
    logic          src_inc  = 1'b0;
    logic          dst_inc  = 1'b0;
    logic          bus_gnt  = 1'b0;
    logic          bus_req;
    logic          mem_we;
    logic [31:0]   mem_a;
    logic [31:0]   mem_wd;
    logic [31:0]   mem_rd;
    logic          busy;
    logic          done;
    logic          error;

    logic [31:0] ram     [0:255];
    logic [31:0] ref_ram [0:255];
    logic [31:0] adc_value = 32'h0000_05A5;

    int cyc       = 0;
    int n_checks  = 0;
    int n_fail    = 0;
    int last_done = -1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_wr[$];
    int          exp_done[$];
    int          exp_err[$];
    logic [31:0] rd_log[$];

    dma_copy #(.LEN_W(LW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .src_inc  (src_inc),
        .dst_inc  (dst_inc),
        .bus_req  (bus_req),
        .bus_gnt  (bus_gnt),
        .mem_we   (mem_we),
        .mem_a    (mem_a),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        if (i < 4) return 32'((i + 1) * 11);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    // Memory map: ADC register at ADC_ADDR, everything else aliases onto 256 words.
    always_comb begin
        if (mem_a == ADC_ADDR) mem_rd = adc_value;
        else                   mem_rd = ram[mem_a[9:2]];
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_we) ram[mem_a[9:2]] <= mem_wd;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: observed 0x%08h with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    // Reference: each word is read then written in order, addresses wrap at 2^32.
    function automatic void model_xfer(input logic [31:0] s, input logic [31:0] d, input int nw,
                                       input bit si, input bit di);
        logic [31:0] sa, da, v;
        wr_t w;
        for (int i = 0; i < nw; i++) begin
            sa = s + (si ? 32'(4 * i) : 32'd0);
            da = d + (di ? 32'(4 * i) : 32'd0);
            v  = (sa == ADC_ADDR) ? adc_value : ref_ram[sa[9:2]];
            ref_ram[da[9:2]] = v;
            w.a = da;
            w.d = v;
            exp_wr.push_back(w);
        end
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_bus_req"}, 32'(bus_req), 32'd0);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_done"},    32'(done),    32'd0);
        check({tag, "_error"},   32'(error),   32'd0);
        check({tag, "_mem_we"},  32'(mem_we),  32'd0);
        check({tag, "_mem_a"},   mem_a,        32'd0);
        check({tag, "_mem_wd"},  mem_wd,       32'd0);
    endtask

    // Monitor: pops expectations whenever the DUT shows a write, done or error.
    initial begin
        wr_t w;
        int  e;
        forever begin
            @(negedge clk);
            #2;
            check("busy_vs_bus_req", 32'(busy), 32'(bus_req));
            if (!bus_gnt || !busy) check("we_without_grant", 32'(mem_we), 32'd0);
            if (!busy) begin
                check("mem_a_idle",  mem_a,  32'd0);
                check("mem_wd_idle", mem_wd, 32'd0);
            end
            if (mem_we) begin
                if (exp_wr.size() == 0) fail_event("unexpected_write", mem_a);
                else begin
                    w = exp_wr.pop_front();
                    check("write_addr", mem_a,  w.a);
                    check("write_data", mem_wd, w.d);
                end
            end
            if (done) begin
                last_done = cyc;
                if (exp_done.size() == 0) fail_event("unexpected_done", 32'(cyc));
                else begin
                    e = exp_done.pop_front();
                    check("done_cycle", 32'(cyc), 32'(e));
                end
            end
            if (error) begin
                if (exp_err.size() == 0) fail_event("unexpected_error", 32'(cyc));
                else begin
                    e = exp_err.pop_front();
                    check("error_cycle", 32'(cyc), 32'(e));
                end
            end
        end
    end

    task automatic noise();
        start    = 1'($urandom_range(0, 1));
        src_addr = $urandom;
        dst_addr = $urandom;
        len      = LW'($urandom_range(0, 3));
        src_inc  = 1'($urandom_range(0, 1));
        dst_inc  = 1'($urandom_range(0, 1));
    endtask

    // Drives one transfer. A word costs two granted cycles plus one grant for the request.
    task automatic xfer(input logic [31:0] s, input logic [31:0] d, input int n, input bit si,
                        input bit di, input int gnt_pct, input int drop_at, input int rst_at,
                        output int c0);
        int granted;
        bit g;
        @(negedge clk);
        c0 = cyc + 1;
        last_done = -1;
        model_xfer(s, d, (rst_at >= 0) ? 1 : n, si, di);
        src_addr = s;
        dst_addr = d;
        len      = LW'(n);
        src_inc  = si;
        dst_inc  = di;
        start    = 1'b1;
        bus_gnt  = 1'($urandom_range(0, 1));
        granted  = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (k == rst_at) begin
                reset = 1'b0;
                #1;
                check_all_zero("reset_mid_xfer");
                @(negedge clk);
                reset = 1'b1;
                start = 1'b0;
                return;
            end
            noise();
            if (granted == 2 * n + 1) begin
                @(negedge clk);
                start = 1'b0;
                return;
            end
            if (drop_at >= 0 && k >= drop_at && k < drop_at + 3) g = 1'b0;
            else g = ($urandom_range(1, 100) <= gnt_pct);
            bus_gnt = g;
            if (g) begin
                granted++;
                if (granted == 2 * n + 1) exp_done.push_back(c0 + k + 1);
            end
            if (gnt_pct == 100 && drop_at < 0 && (k % 2) == 1 && k < 2 * n) begin
                #1;
                rd_log.push_back(mem_a);
            end
        end
        fail_event("xfer_grant_budget", 32'(granted));
        start = 1'b0;
    endtask

    task automatic bad_start(input logic [31:0] s, input logic [31:0] d, input int n);
        @(negedge clk);
        exp_err.push_back(cyc + 1);
        src_addr = s;
        dst_addr = d;
        len      = LW'(n);
        start    = 1'b1;
        bus_gnt  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            check("busy_after_reject", 32'(busy), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        int          c0, n;
        logic [31:0] s, d;
        bit          si, di;

        for (int i = 0; i < 256; i++) ref_ram[i] = init_word(i);
        repeat (3) @(negedge clk);
        check_all_zero("in_reset");
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");

        rd_log.delete();
        xfer(32'h0, 32'h40, 4, 1'b1, 1'b1, 100, -1, -1, c0);
        check("basic_done_cycle", 32'(last_done - c0 + 1), 32'd10);
        for (int i = 0; i < 4; i++) check("basic_dst_word", ram[16 + i], 32'((i + 1) * 11));
        check("basic_read_count", 32'(rd_log.size()), 32'd4);
        for (int i = 0; i < rd_log.size(); i++) check("basic_read_addr", rd_log[i], 32'(4 * i));

        adc_value = 32'h0000_05A5;
        rd_log.delete();
        xfer(ADC_ADDR, 32'h80, 3, 1'b0, 1'b1, 100, -1, -1, c0);
        for (int i = 0; i < 3; i++) check("adc_dst_word", ram[32 + i], 32'h0000_05A5);
        check("adc_read_count", 32'(rd_log.size()), 32'd3);
        for (int i = 0; i < rd_log.size(); i++) check("adc_read_addr_fixed", rd_log[i], ADC_ADDR);

        bad_start(32'h2, 32'h100, 1);
        bad_start(32'h0, 32'h101, 1);
        bad_start(32'h0, 32'h100, 0);

        xfer(32'h200, 32'h300, 4, 1'b1, 1'b1, 100, 4, -1, c0);
        check("stall_done_cycle", 32'(last_done - c0 + 1), 32'd13);

        xfer(32'h0, 32'h380, 4, 1'b1, 1'b1, 100, -1, 3, c0);
        @(negedge clk);
        check("reset_first_word", ram[224], 32'd11);
        for (int i = 1; i < 4; i++) check("reset_untouched_word", ram[224 + i], init_word(224 + i));

        xfer(32'hFFFF_FFF8, 32'hFFFF_FFFC, 3, 1'b1, 1'b1, 100, -1, -1, c0);

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 5) == 0) begin
                s = {22'd0, 8'($urandom), 2'($urandom_range(0, 1))};
                d = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
                bad_start(s, d, $urandom_range(0, 3));
            end
            n  = $urandom_range(1, 12);
            si = 1'($urandom_range(0, 1));
            di = 1'($urandom_range(0, 1));
            s  = {22'd0, 8'($urandom), 2'b00};
            d  = {22'd0, 8'($urandom), 2'b00};
            if ($urandom_range(0, 7) == 0) begin
                s  = ADC_ADDR;
                si = 1'b0;
            end
            adc_value = $urandom;
            xfer(s, d, n, si, di, $urandom_range(40, 100), -1, -1, c0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("pending_writes", 32'(exp_wr.size()), 32'd0);
        check("pending_done",   32'(exp_done.size()), 32'd0);
        check("pending_error",  32'(exp_err.size()), 32'd0);
        for (int i = 0; i < 256; i++) check("final_ram", ram[i], ref_ram[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
